// File: rtl/kernel_pkg.sv
// Shared types and constants for the Gaussian-kernel sequencing controller.
package kernel_pkg;

    localparam int          MAX_KERNAL_DEFAULT = 7;
    localparam int unsigned KS_MIN             = 3;

    typedef enum logic [2:0] {
        ST_EMPTY,
        ST_READY,
        ST_DRAIN,
        ST_LAUNCH,
        ST_BUILD
    } kctrl_state_t;

    typedef enum logic [1:0] {
        KERR_NONE,
        KERR_BAD_CFG,
        KERR_GEN,
        KERR_TIMEOUT
    } kerr_t;

    // Kernels are odd, non-degenerate squares with a non-zero sigma.
    function automatic logic cfg_ok(input logic [2:0] sigma, input int unsigned size,
                                    input int unsigned max_k);
        return (sigma != 3'd0) && size[0] && (size >= KS_MIN) && (size <= max_k);
    endfunction

endpackage

// File: rtl/kernel_timer.sv
// Clearable build-watchdog counter; expired is high during the last allowed BUILD cycle,
// so the owning FSM leaves BUILD exactly LIMIT edges after it entered.
module kernel_timer #(
    parameter int LIMIT = 255,
    parameter int TW    = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && count != TW'(LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = en && (count == TW'(LIMIT - 1));

endmodule

// File: rtl/kernel_ctrl.sv
// Sequencer for the CreateKernel generator: validates/caches configs, drains the consumer,
// launches the generator and supervises done/err/timeout. All outputs registered or state-decoded.
module kernel_ctrl
    import kernel_pkg::*;
#(
    parameter int MAX_KERNAL     = MAX_KERNAL_DEFAULT,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int SZW            = $clog2(MAX_KERNAL)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [2:0]     cfg_sigma,
    input  logic [SZW-1:0] cfg_size,
    output logic           cfg_done,
    output logic [1:0]     err_code,
    input  logic           conv_busy,
    output logic           kernel_valid,
    output logic [2:0]     cur_sigma,
    output logic [SZW-1:0] cur_size,
    output logic           gen_start,
    output logic [2:0]     gen_sigma,
    output logic [SZW-1:0] gen_size,
    input  logic           gen_done,
    input  logic           gen_err
);

    kctrl_state_t state;
    kerr_t        err_q;
    logic         req_ok;
    logic         req_hit;
    logic         timer_expired;

    assign req_ok  = cfg_ok(cfg_sigma, 32'(cfg_size), MAX_KERNAL);
    assign req_hit = (state == ST_READY) && (cfg_sigma == cur_sigma) && (cfg_size == cur_size);

    kernel_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (state == ST_LAUNCH),
        .en      (state == ST_BUILD),
        .expired (timer_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_EMPTY;
            err_q     <= KERR_NONE;
            cfg_done  <= 1'b0;
            cur_sigma <= '0;
            cur_size  <= '0;
            gen_start <= 1'b0;
            gen_sigma <= '0;
            gen_size  <= '0;
        end else begin
            cfg_done  <= 1'b0;
            gen_start <= 1'b0;
            case (state)
                ST_EMPTY, ST_READY: begin
                    if (cfg_valid) begin
                        if (!req_ok) begin
                            err_q    <= KERR_BAD_CFG;
                            cfg_done <= 1'b1;
                        end else if (req_hit) begin
                            err_q    <= KERR_NONE;
                            cfg_done <= 1'b1;
                        end else begin
                            gen_sigma <= cfg_sigma;
                            gen_size  <= cfg_size;
                            state     <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!conv_busy) begin
                        state     <= ST_LAUNCH;
                        gen_start <= 1'b1;
                    end
                end
                ST_LAUNCH: state <= ST_BUILD;
                ST_BUILD: begin
                    // A done landing on the expiry cycle still counts as a completion.
                    if (gen_done) begin
                        cfg_done <= 1'b1;
                        if (gen_err) begin
                            err_q <= KERR_GEN;
                            state <= ST_EMPTY;
                        end else begin
                            err_q     <= KERR_NONE;
                            cur_sigma <= gen_sigma;
                            cur_size  <= gen_size;
                            state     <= ST_READY;
                        end
                    end else if (timer_expired) begin
                        err_q    <= KERR_TIMEOUT;
                        cfg_done <= 1'b1;
                        state    <= ST_EMPTY;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

    assign cfg_ready    = (state == ST_EMPTY) || (state == ST_READY);
    assign kernel_valid = (state == ST_READY);
    assign err_code     = err_q;

endmodule
